// File: rtl/dcache_bus_arbiter_pkg.sv
// Shared types and constants for the Dcache snooping bus controller.
package dcache_bus_arbiter_pkg;

  localparam int DCACHE_TAG_W        = 52;
  localparam int DCACHE_IDX_W        = 9;
  localparam int DCACHE_WORD_IN_BITS = 64;
  localparam int BUS_ADDR_W          = 64;

  // Coherence message carried between Dcache and the bus
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  // Bus controller FSM; WB only exists in the snoop-writeback build
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_SNOOP    = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
`ifdef BUS_SNOOP_WB_EN
    ST_RSP      = 3'd5,
    ST_WB       = 3'd6
`else
    ST_RSP      = 3'd5
`endif
  } bus_state_t;

  // Memory byte address of a cache line: {tag, idx, 3'b000}
  function automatic logic [BUS_ADDR_W-1:0] line_addr(
    input logic [DCACHE_TAG_W-1:0] tag,
    input logic [DCACHE_IDX_W-1:0] idx
  );
    return {tag, idx, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_bus_arbiter_if.sv
// Bundle of requester, snoop, response and memory signals of the bus controller.
// master = the bus controller, slave = the caches/memory side.
interface dcache_bus_arbiter_if #(
  parameter int NUM_CORE  = 2,
  parameter int CORE_ID_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
);
  import dcache_bus_arbiter_pkg::*;

  logic [NUM_CORE-1:0]                          Dcache2bus_req_en_i;
  logic [NUM_CORE-1:0][DCACHE_TAG_W-1:0]        Dcache2bus_req_tag_i;
  logic [NUM_CORE-1:0][DCACHE_IDX_W-1:0]        Dcache2bus_req_idx_i;
  logic [NUM_CORE-1:0][DCACHE_WORD_IN_BITS-1:0] Dcache2bus_req_data_i;
  message_t                                     Dcache2bus_req_message_i [NUM_CORE];
  logic [NUM_CORE-1:0]                          bus2Dcache_req_ack_o;

  logic [CORE_ID_W-1:0]                         bus2Dcache_req_id_o;
  logic [DCACHE_TAG_W-1:0]                      bus2Dcache_req_tag_o;
  logic [DCACHE_IDX_W-1:0]                      bus2Dcache_req_idx_o;
  message_t                                     bus2Dcache_req_message_o;

  logic [NUM_CORE-1:0]                          Dcache2bus_rsp_vld_i;
  logic [NUM_CORE-1:0][DCACHE_WORD_IN_BITS-1:0] Dcache2bus_rsp_data_i;

  logic                                         bus2Dcache_rsp_vld_o;
  logic [CORE_ID_W-1:0]                         bus2Dcache_rsp_id_o;
  logic [DCACHE_WORD_IN_BITS-1:0]               bus2Dcache_rsp_data_o;
  logic [NUM_CORE-1:0]                          Dcache2bus_rsp_ack_i;

  logic                                         bus2mem_req_en_o;
  logic                                         bus2mem_req_wr_o;
  logic [63:0]                                  bus2mem_addr_o;
  logic [63:0]                                  bus2mem_data_o;
  logic                                         mem2bus_req_ack_i;
  logic                                         mem2bus_rsp_vld_i;
  logic [63:0]                                  mem2bus_rsp_data_i;

  modport master (
    input  Dcache2bus_req_en_i, Dcache2bus_req_tag_i, Dcache2bus_req_idx_i,
           Dcache2bus_req_data_i, Dcache2bus_req_message_i,
           Dcache2bus_rsp_vld_i, Dcache2bus_rsp_data_i, Dcache2bus_rsp_ack_i,
           mem2bus_req_ack_i, mem2bus_rsp_vld_i, mem2bus_rsp_data_i,
    output bus2Dcache_req_ack_o, bus2Dcache_req_id_o, bus2Dcache_req_tag_o,
           bus2Dcache_req_idx_o, bus2Dcache_req_message_o,
           bus2Dcache_rsp_vld_o, bus2Dcache_rsp_id_o, bus2Dcache_rsp_data_o,
           bus2mem_req_en_o, bus2mem_req_wr_o, bus2mem_addr_o, bus2mem_data_o
  );

  modport slave (
    output Dcache2bus_req_en_i, Dcache2bus_req_tag_i, Dcache2bus_req_idx_i,
           Dcache2bus_req_data_i, Dcache2bus_req_message_i,
           Dcache2bus_rsp_vld_i, Dcache2bus_rsp_data_i, Dcache2bus_rsp_ack_i,
           mem2bus_req_ack_i, mem2bus_rsp_vld_i, mem2bus_rsp_data_i,
    input  bus2Dcache_req_ack_o, bus2Dcache_req_id_o, bus2Dcache_req_tag_o,
           bus2Dcache_req_idx_o, bus2Dcache_req_message_o,
           bus2Dcache_rsp_vld_o, bus2Dcache_rsp_id_o, bus2Dcache_rsp_data_o,
           bus2mem_req_en_o, bus2mem_req_wr_o, bus2mem_addr_o, bus2mem_data_o
  );

endinterface

// File: rtl/dcache_bus_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_CORE  = 2,
  parameter int CORE_ID_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic [NUM_CORE-1:0]  i_req,
  input  logic [CORE_ID_W-1:0] i_ptr,
  output logic                 o_vld,
  output logic [CORE_ID_W-1:0] o_id
);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester overrides
  always_comb begin
    o_vld = 1'b0;
    o_id  = '0;
    w_idx = 0;
    for (int off = NUM_CORE - 1; off >= 0; off--) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= NUM_CORE) begin
        w_idx = w_idx - NUM_CORE;
      end else begin
        w_idx = w_idx;
      end
      if (i_req[w_idx]) begin
        o_vld = 1'b1;
        o_id  = CORE_ID_W'(w_idx);
      end else begin
        o_vld = o_vld;
      end
    end
  end

endmodule

// File: rtl/dcache_bus_arbiter.sv
// Snooping bus controller: grants one Dcache request at a time (round-robin),
// broadcasts it for snooping, sources data from an owner cache or memory and
// holds the response until the requester acks it.
// Optional feature macro: BUS_SNOOP_WB_EN (snoop-supplied GET_S data is also
// written back to memory before the response).
module dcache_bus_arbiter #(
  parameter int NUM_CORE  = 2,
  parameter int CORE_ID_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input logic                  clk,
  input logic                  rst,
  dcache_bus_arbiter_if.master bus
);
  import dcache_bus_arbiter_pkg::*;

  bus_state_t                     r_state, w_state_nxt;
  logic [CORE_ID_W-1:0]           r_rr_ptr, r_id, w_ptr_nxt, w_gnt_id;
  logic [DCACHE_TAG_W-1:0]        r_tag;
  logic [DCACHE_IDX_W-1:0]        r_idx;
  logic [DCACHE_WORD_IN_BITS-1:0] r_data, w_snp_data;
  message_t                       r_msg;
  logic                           w_gnt_vld, w_snp_vld;
  logic                           w_lat_req, w_lat_snoop, w_lat_mem, w_ptr_adv;

  logic [NUM_CORE-1:0]            w_req_ack;
  logic [CORE_ID_W-1:0]           w_bc_id, w_rsp_id;
  logic [DCACHE_TAG_W-1:0]        w_bc_tag;
  logic [DCACHE_IDX_W-1:0]        w_bc_idx;
  message_t                       w_bc_msg;
  logic                           w_rsp_vld, w_mem_en, w_mem_wr;
  logic [DCACHE_WORD_IN_BITS-1:0] w_rsp_data;
  logic [63:0]                    w_mem_addr, w_mem_data;

  rr_arbiter #(.NUM_CORE(NUM_CORE), .CORE_ID_W(CORE_ID_W)) u_rr_arbiter (
    .i_req (bus.Dcache2bus_req_en_i),
    .i_ptr (r_rr_ptr),
    .o_vld (w_gnt_vld),
    .o_id  (w_gnt_id)
  );

  assign w_ptr_nxt = (r_id == CORE_ID_W'(NUM_CORE - 1)) ? '0 : r_id + CORE_ID_W'(1);

  // Lowest-index snooper that is not the requester supplies the data
  always_comb begin
    w_snp_vld  = 1'b0;
    w_snp_data = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (bus.Dcache2bus_rsp_vld_i[i] && (CORE_ID_W'(i) != r_id)) begin
        w_snp_vld  = 1'b1;
        w_snp_data = bus.Dcache2bus_rsp_data_i[i];
      end else begin
        w_snp_vld  = w_snp_vld;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the granted request, advance the pointer and latch response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_msg    <= NONE;
    end else begin
      if (w_lat_req) begin
        r_id   <= w_gnt_id;
        r_tag  <= bus.Dcache2bus_req_tag_i[w_gnt_id];
        r_idx  <= bus.Dcache2bus_req_idx_i[w_gnt_id];
        r_data <= bus.Dcache2bus_req_data_i[w_gnt_id];
        r_msg  <= bus.Dcache2bus_req_message_i[w_gnt_id];
      end else if (w_lat_snoop) begin
        r_data <= w_snp_data;
      end else if (w_lat_mem) begin
        r_data <= bus.mem2bus_rsp_data_i;
      end
      if (w_ptr_adv) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Next-state and output decode; every output idles at zero / NONE
  always_comb begin
    w_state_nxt = r_state;
    w_lat_req   = 1'b0;
    w_lat_snoop = 1'b0;
    w_lat_mem   = 1'b0;
    w_ptr_adv   = 1'b0;
    w_req_ack   = '0;
    w_bc_id     = '0;
    w_bc_tag    = '0;
    w_bc_idx    = '0;
    w_bc_msg    = NONE;
    w_rsp_vld   = 1'b0;
    w_rsp_id    = '0;
    w_rsp_data  = '0;
    w_mem_en    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_lat_req   = 1'b1;
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_req_ack[r_id] = 1'b1;
        w_bc_id         = r_id;
        w_bc_tag        = r_tag;
        w_bc_idx        = r_idx;
        w_bc_msg        = r_msg;
        w_ptr_adv       = 1'b1;
        if (r_msg == PUT_M) begin
          w_state_nxt = ST_MEM_REQ;
        end else begin
          w_state_nxt = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        if (w_snp_vld) begin
          w_lat_snoop = 1'b1;
`ifdef BUS_SNOOP_WB_EN
          if (r_msg == GET_S) begin
            w_state_nxt = ST_WB;
          end else begin
            w_state_nxt = ST_RSP;
          end
`else
          w_state_nxt = ST_RSP;
`endif
        end else begin
          w_state_nxt = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        w_mem_en   = 1'b1;
        w_mem_wr   = (r_msg == PUT_M);
        w_mem_addr = line_addr(r_tag, r_idx);
        if (r_msg == PUT_M) begin
          w_mem_data = r_data;
        end else begin
          w_mem_data = '0;
        end
        if (bus.mem2bus_req_ack_i) begin
          if (r_msg == PUT_M) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
          end
        end else begin
          w_state_nxt = ST_MEM_REQ;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem2bus_rsp_vld_i) begin
          w_lat_mem   = 1'b1;
          w_state_nxt = ST_RSP;
        end else begin
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      ST_RSP: begin
        w_rsp_vld  = 1'b1;
        w_rsp_id   = r_id;
        w_rsp_data = r_data;
        if (bus.Dcache2bus_rsp_ack_i[r_id]) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RSP;
        end
      end
`ifdef BUS_SNOOP_WB_EN
      ST_WB: begin
        w_mem_en   = 1'b1;
        w_mem_wr   = 1'b1;
        w_mem_addr = line_addr(r_tag, r_idx);
        w_mem_data = r_data;
        if (bus.mem2bus_req_ack_i) begin
          w_state_nxt = ST_RSP;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.bus2Dcache_req_ack_o     = w_req_ack;
  assign bus.bus2Dcache_req_id_o      = w_bc_id;
  assign bus.bus2Dcache_req_tag_o     = w_bc_tag;
  assign bus.bus2Dcache_req_idx_o     = w_bc_idx;
  assign bus.bus2Dcache_req_message_o = w_bc_msg;
  assign bus.bus2Dcache_rsp_vld_o     = w_rsp_vld;
  assign bus.bus2Dcache_rsp_id_o      = w_rsp_id;
  assign bus.bus2Dcache_rsp_data_o    = w_rsp_data;
  assign bus.bus2mem_req_en_o         = w_mem_en;
  assign bus.bus2mem_req_wr_o         = w_mem_wr;
  assign bus.bus2mem_addr_o           = w_mem_addr;
  assign bus.bus2mem_data_o           = w_mem_data;

endmodule

// File: tb/tb_dcache_bus_arbiter.sv
// Self-checking bench for dcache_bus_arbiter: directed cases from the test
// plan followed by randomized transactions against a transaction-level model.
module tb_dcache_bus_arbiter;
  import dcache_bus_arbiter_pkg::*;

  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr;

  logic [NC-1:0]              req_en;
  logic [DCACHE_TAG_W-1:0]    req_tag  [NC];
  logic [DCACHE_IDX_W-1:0]    req_idx  [NC];
  logic [63:0]                req_data [NC];
  message_t                   req_msg  [NC];
  logic [NC-1:0]              snp_vld, snp_mask, rsp_ack;
  logic [63:0]                snp_data [NC];
  logic                       mem_ack, mem_rsp_vld;
  logic [63:0]                mem_rsp_data, mem_rd_data;
  int                         mem_ack_dly, mem_rsp_dly, rsp_ack_dly;

  dcache_bus_arbiter_if #(.NUM_CORE(NC)) bus_if();

  dcache_bus_arbiter #(.NUM_CORE(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.Dcache2bus_req_en_i  = req_en;
  assign bus_if.Dcache2bus_rsp_vld_i = snp_vld;
  assign bus_if.Dcache2bus_rsp_ack_i = rsp_ack;
  assign bus_if.mem2bus_req_ack_i    = mem_ack;
  assign bus_if.mem2bus_rsp_vld_i    = mem_rsp_vld;
  assign bus_if.mem2bus_rsp_data_i   = mem_rsp_data;
  for (genvar g = 0; g < NC; g++) begin : g_drv
    assign bus_if.Dcache2bus_req_tag_i[g]     = req_tag[g];
    assign bus_if.Dcache2bus_req_idx_i[g]     = req_idx[g];
    assign bus_if.Dcache2bus_req_data_i[g]    = req_data[g];
    assign bus_if.Dcache2bus_req_message_i[g] = req_msg[g];
    assign bus_if.Dcache2bus_rsp_data_i[g]    = snp_data[g];
  end

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_value({tag, "_ack"},     64'(bus_if.bus2Dcache_req_ack_o), 64'd0);
    check_value({tag, "_bc_id"},   64'(bus_if.bus2Dcache_req_id_o), 64'd0);
    check_value({tag, "_bc_tag"},  64'(bus_if.bus2Dcache_req_tag_o), 64'd0);
    check_value({tag, "_bc_idx"},  64'(bus_if.bus2Dcache_req_idx_o), 64'd0);
    check_value({tag, "_bc_msg"},  64'(bus_if.bus2Dcache_req_message_o), 64'(NONE));
    check_value({tag, "_rsp_vld"}, 64'(bus_if.bus2Dcache_rsp_vld_o), 64'd0);
    check_value({tag, "_rsp_id"},  64'(bus_if.bus2Dcache_rsp_id_o), 64'd0);
    check_value({tag, "_rsp_dat"}, 64'(bus_if.bus2Dcache_rsp_data_o), 64'd0);
    check_value({tag, "_mem_en"},  64'(bus_if.bus2mem_req_en_o), 64'd0);
    check_value({tag, "_mem_wr"},  64'(bus_if.bus2mem_req_wr_o), 64'd0);
    check_value({tag, "_mem_adr"}, bus_if.bus2mem_addr_o, 64'd0);
    check_value({tag, "_mem_dat"}, bus_if.bus2mem_data_o, 64'd0);
  endtask

  // New requests from cores in mask that are not already waiting
  task automatic add_req(input logic [NC-1:0] mask);
    for (int c = 0; c < NC; c++) begin
      if (mask[c] && !req_en[c]) begin
        req_en[c]   = 1'b1;
        req_tag[c]  = DCACHE_TAG_W'({$urandom, $urandom});
        req_idx[c]  = DCACHE_IDX_W'($urandom);
        req_data[c] = {$urandom, $urandom};
        req_msg[c]  = message_t'(2'($urandom_range(1, 3)));
      end
    end
  endtask

  task automatic rand_env();
    snp_mask    = NC'($urandom);
    for (int c = 0; c < NC; c++) snp_data[c] = {$urandom, $urandom};
    mem_rd_data = {$urandom, $urandom};
    mem_ack_dly = $urandom_range(0, 3);
    mem_rsp_dly = $urandom_range(0, 3);
    rsp_ack_dly = $urandom_range(0, 3);
  endtask

  // Memory request phase: check it is held until ack, then ack it
  task automatic mem_phase(input bit wr, input logic [63:0] addr, input logic [63:0] data);
    for (int i = 0; i <= mem_ack_dly; i++) begin
      check_value("mem_en",  64'(bus_if.bus2mem_req_en_o), 64'd1);
      check_value("mem_wr",  64'(bus_if.bus2mem_req_wr_o), 64'(wr));
      check_value("mem_adr", bus_if.bus2mem_addr_o, addr);
      if (wr) check_value("mem_dat", bus_if.bus2mem_data_o, data);
      check_value("rsp_vld_in_mem", 64'(bus_if.bus2Dcache_rsp_vld_o), 64'd0);
      mem_ack = (i == mem_ack_dly);
      step();
    end
    mem_ack = 1'b0;
  endtask

  // One complete transaction starting from IDLE with requests already posted
  task automatic do_txn();
    int            w;
    int            src;
    logic [NC-1:0] wbit;
    logic [NC-1:0] others;
    logic [63:0]   addr;
    logic [63:0]   exp_data;
    w = -1;
    for (int k = 0; k < NC; k++) begin
      if (w < 0 && req_en[(m_ptr + k) % NC]) w = (m_ptr + k) % NC;
    end
    wbit    = '0;
    wbit[w] = 1'b1;
    addr    = {req_tag[w], req_idx[w], 3'b000};
    snp_vld = snp_mask;
    step();
    check_value("grant_ack", 64'(bus_if.bus2Dcache_req_ack_o), 64'(wbit));
    check_value("bc_id",     64'(bus_if.bus2Dcache_req_id_o), 64'(w));
    check_value("bc_tag",    64'(bus_if.bus2Dcache_req_tag_o), 64'(req_tag[w]));
    check_value("bc_idx",    64'(bus_if.bus2Dcache_req_idx_o), 64'(req_idx[w]));
    check_value("bc_msg",    64'(bus_if.bus2Dcache_req_message_o), 64'(req_msg[w]));
    req_en[w] = 1'b0;
    m_ptr     = (w + 1) % NC;
    if (req_msg[w] == PUT_M) begin
      step();
      mem_phase(1'b1, addr, req_data[w]);
      snp_vld = '0;
    end else begin
      others = snp_mask & ~wbit;
      step();
      check_value("snoop_msg", 64'(bus_if.bus2Dcache_req_message_o), 64'(NONE));
      check_value("snoop_mem", 64'(bus_if.bus2mem_req_en_o), 64'd0);
      step();
      snp_vld = '0;
      if (others != '0) begin
        src = others[0] ? 0 : 1;
        exp_data = snp_data[src];
`ifdef BUS_SNOOP_WB_EN
        if (req_msg[w] == GET_S) mem_phase(1'b1, addr, exp_data);
`endif
      end else begin
        mem_phase(1'b0, addr, 64'd0);
        for (int i = 0; i <= mem_rsp_dly; i++) begin
          check_value("wait_mem_en",  64'(bus_if.bus2mem_req_en_o), 64'd0);
          check_value("wait_rsp_vld", 64'(bus_if.bus2Dcache_rsp_vld_o), 64'd0);
          mem_rsp_vld  = (i == mem_rsp_dly);
          mem_rsp_data = mem_rd_data;
          step();
        end
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = 64'd0;
        exp_data     = mem_rd_data;
      end
      for (int i = 0; i <= rsp_ack_dly; i++) begin
        check_value("rsp_vld",  64'(bus_if.bus2Dcache_rsp_vld_o), 64'd1);
        check_value("rsp_id",   64'(bus_if.bus2Dcache_rsp_id_o), 64'(w));
        check_value("rsp_data", bus_if.bus2Dcache_rsp_data_o, exp_data);
        rsp_ack = (i == rsp_ack_dly) ? wbit : (NC'($urandom) & ~wbit);
        step();
      end
      rsp_ack = '0;
    end
    check_value("end_rsp_vld", 64'(bus_if.bus2Dcache_rsp_vld_o), 64'd0);
    check_value("end_mem_en",  64'(bus_if.bus2mem_req_en_o), 64'd0);
    check_value("end_msg",     64'(bus_if.bus2Dcache_req_message_o), 64'(NONE));
  endtask

  initial begin
    logic [NC-1:0] nm;
    rst = 1'b1;
    req_en = '0; snp_vld = '0; snp_mask = '0; rsp_ack = '0;
    mem_ack = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = 64'd0; mem_rd_data = 64'd0;
    mem_ack_dly = 0; mem_rsp_dly = 0; rsp_ack_dly = 0;
    for (int c = 0; c < NC; c++) begin
      req_tag[c] = '0; req_idx[c] = '0; req_data[c] = 64'd0;
      req_msg[c] = NONE; snp_data[c] = 64'd0;
    end
    m_ptr = 0;
    #1;
    check_quiet("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    // Simultaneous requests: core0, then core1, then core0 again
    rand_env(); add_req(2'b11); do_txn();
    rand_env(); do_txn();
    rand_env(); add_req(2'b11); do_txn();
    rand_env(); do_txn();

    // Core0 GET_S 0x1A/2 served by memory with 0xDEAD
    rand_env(); snp_mask = 2'b00; mem_rd_data = 64'hDEAD;
    req_en[0] = 1'b1; req_tag[0] = DCACHE_TAG_W'(8'h1A); req_idx[0] = DCACHE_IDX_W'(2);
    req_msg[0] = GET_S; do_txn();

    // Core1 GET_M, core0 snoop supplies 0xBEEF
    rand_env(); snp_mask = 2'b01; snp_data[0] = 64'hBEEF;
    req_en[1] = 1'b1; req_msg[1] = GET_M; do_txn();

    // Core0 PUT_M 0x1234 with memory ack delayed 5 cycles
    rand_env(); mem_ack_dly = 5;
    req_en[0] = 1'b1; req_msg[0] = PUT_M; req_data[0] = 64'h1234; do_txn();

    // Core1 GET_S, core0 supplies 0x55 (writeback first in the WB build)
    rand_env(); snp_mask = 2'b11; snp_data[0] = 64'h55; snp_data[1] = 64'h77;
    req_en[1] = 1'b1; req_msg[1] = GET_S; do_txn();

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      rand_env();
      nm = NC'($urandom);
      if ((req_en | nm) == '0) nm = 2'b01;
      add_req(nm);
      do_txn();
    end
    // Drain any request still waiting
    while (req_en != '0) begin
      rand_env();
      do_txn();
    end

    // Reset during MEM_WAIT aborts the transaction
    snp_mask = 2'b00; snp_vld = 2'b00;
    req_en[0] = 1'b1; req_msg[0] = GET_S;
    step();
    req_en[0] = 1'b0;
    step();
    step();
    check_value("rst_tc_mem_en", 64'(bus_if.bus2mem_req_en_o), 64'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_value("rst_tc_wait", 64'(bus_if.bus2mem_req_en_o), 64'd0);
    rst = 1'b1;
    #1;
    check_quiet("mid_reset");
    step();
    rst = 1'b0;
    mem_rsp_vld = 1'b1; mem_rsp_data = 64'hCAFE;
    step();
    mem_rsp_vld = 1'b0;
    check_value("stale_mem_rsp", 64'(bus_if.bus2Dcache_rsp_vld_o), 64'd0);
    step();
    check_quiet("after_reset_idle");

    // Pointer restarts at core0 after reset
    m_ptr = 0;
    rand_env(); add_req(2'b11); do_txn();
    rand_env(); do_txn();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
